// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiplier sequencer: default widths
// and the job-engine state encoding.
package vec_mul_pkg;

    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_CNT_BW      = 8;

    // Job engine states, in the order a full job walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WPOP   = 3'd1,
        ST_WLAT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seqState_e;

endpackage

// File: rtl/vec_mul_valid_pipe.sv
// PIPE_LAT-deep valid shift register that mirrors the vec_mul pipeline.
// tap_o marks the cycle a result is ready to be written back; empty_o means
// nothing will be left in flight once the current cycle's shift completes.
module vec_mul_valid_pipe #(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic tap_o,
    output logic empty_o
);

    logic [PIPE_LAT-1:0] pipe_q;

    generate
        if (PIPE_LAT == 1) begin : g_single
            // Single stage: the valid bit simply follows the issue by one cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= valid_i;
                end
            end

            assign empty_o = ~valid_i;
        end else begin : g_multi
            // Shift each issued valid bit one stage towards the tap per cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= {pipe_q[PIPE_LAT-2:0], valid_i};
                end
            end

            // The tap stage leaves this cycle, so only the earlier stages and
            // the incoming bit decide whether anything remains in flight.
            assign empty_o = ~valid_i && (pipe_q[PIPE_LAT-2:0] == '0);
        end
    endgenerate

    assign tap_o = pipe_q[PIPE_LAT-1];

endmodule

// File: rtl/vec_mul_seq_ctrl.sv
// Start/done job engine for the UB -> vec_mul -> results SRAM datapath.
// Optionally pops new weights, streams vec_count UB addresses and writes
// each result row back PIPE_LAT cycles after its address was issued.
module vec_mul_seq_ctrl
    import vec_mul_pkg::*;
#(
    parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
    parameter int CNT_BW      = DEF_CNT_BW,
    parameter int PIPE_LAT    = 3,
    parameter int WLOAD_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   load_weights,
    input  logic [CNT_BW-1:0]      vec_count,
    input  logic [ADDRESSSIZE-1:0] ub_base,
    input  logic [ADDRESSSIZE-1:0] res_base,
    input  logic                   fifo_empty,
    output logic                   busy,
    output logic                   done,
    output logic                   err_no_weights,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address
);

    localparam int WL_BW = (WLOAD_LAT > 1) ? $clog2(WLOAD_LAT) : 1;
    localparam logic [WL_BW-1:0] WL_LAST = WL_BW'(WLOAD_LAT - 1);

    seqState_e               state_q, state_d;
    logic [CNT_BW-1:0]       vecCount_q;
    logic [ADDRESSSIZE-1:0]  ubBase_q;
    logic [ADDRESSSIZE-1:0]  resBase_q;
    logic [CNT_BW-1:0]       rdIdx_q;
    logic [CNT_BW-1:0]       wrIdx_q;
    logic [WL_BW-1:0]        wlatCnt_q;
    logic                    errPulse_q;
    logic                    pipeTap;
    logic                    pipeEmpty;
    logic                    acceptStart;

    // Jobs are only taken from IDLE; start at any other time is ignored.
    assign acceptStart = (state_q == ST_IDLE) && start;

    vec_mul_valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_validPipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (state_q == ST_STREAM),
        .tap_o   (pipeTap),
        .empty_o (pipeEmpty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job fields, read/write indices, weight-latency counter and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vecCount_q <= '0;
            ubBase_q   <= '0;
            resBase_q  <= '0;
            rdIdx_q    <= '0;
            wrIdx_q    <= '0;
            wlatCnt_q  <= '0;
            errPulse_q <= 1'b0;
        end else begin
            errPulse_q <= acceptStart && load_weights && fifo_empty;
            if (acceptStart) begin
                vecCount_q <= vec_count;
                ubBase_q   <= ub_base;
                resBase_q  <= res_base;
                rdIdx_q    <= '0;
                wrIdx_q    <= '0;
                wlatCnt_q  <= '0;
            end else begin
                if (state_q == ST_STREAM) begin
                    rdIdx_q <= rdIdx_q + CNT_BW'(1);
                end
                if (pipeTap) begin
                    wrIdx_q <= wrIdx_q + CNT_BW'(1);
                end
                if (state_q == ST_WLAT) begin
                    wlatCnt_q <= wlatCnt_q + WL_BW'(1);
                end
            end
        end
    end

    // Next-state decode plus all control strobes and address generation.
    always_comb begin
        state_d          = state_q;
        busy             = 1'b0;
        done             = 1'b0;
        fifo_read_enable = 1'b0;
        weight_reload    = 1'b0;
        ub_address       = '0;
        res_write_enable = pipeTap;
        res_address      = '0;
        err_no_weights   = errPulse_q;

        if (pipeTap) begin
            res_address = resBase_q + ADDRESSSIZE'(wrIdx_q);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (load_weights) begin
                        if (!fifo_empty) begin
                            state_d = ST_WPOP;
                        end
                    end else if (vec_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_WPOP: begin
                busy             = 1'b1;
                fifo_read_enable = 1'b1;
                state_d          = ST_WLAT;
            end
            ST_WLAT: begin
                busy = 1'b1;
                if (wlatCnt_q == WL_LAST) begin
                    weight_reload = 1'b1;
                    state_d       = (vecCount_q == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy       = 1'b1;
                ub_address = ubBase_q + ADDRESSSIZE'(rdIdx_q);
                if (rdIdx_q == vecCount_q - CNT_BW'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (pipeEmpty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
